// File: rtl/inst_fetch.sv
// Instruction fetch with a prefetch queue between the instruction ROM and if_id.
// Optional macro FETCH_BYPASS_EN lets an empty queue forward the ROM word in the same cycle.
`ifndef NopInst
`define NopInst 32'h00000013
`endif

module inst_fetch #(
    parameter int unsigned QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] addr_o,
    input  logic        rom_stall_i,
    input  logic [31:0] inst_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        stall_req_o
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q   [QDEPTH];
    logic [31:0]   pc_mem_d   [QDEPTH];
    logic [31:0]   inst_mem_q [QDEPTH];
    logic [31:0]   inst_mem_d [QDEPTH];

    logic q_valid_s;
    logic full_s;
    logic pop_s;
    logic push_s;
    logic byp_s;
    logic byp_take_s;
    logic wr_en_s;

    // Handshake decode: what moves into and out of the queue this cycle.
    always_comb begin
        q_valid_s = (count_q != '0);
        full_s    = (count_q == FULL_CNT);
        pop_s     = q_valid_s && !stall_i && !branch_flag_i;
        push_s    = (state_q == S_FETCH) && !rom_stall_i && !branch_flag_i
                    && (!full_s || pop_s);
`ifdef FETCH_BYPASS_EN
        byp_s      = push_s && !q_valid_s;
        byp_take_s = byp_s && !stall_i;
`else
        byp_s      = 1'b0;
        byp_take_s = 1'b0;
`endif
        // A bypassed word consumed by if_id never occupies a queue slot.
        wr_en_s = push_s && !byp_take_s;
    end

    // Head presentation toward if_id; a pending redirect hides stale entries.
    always_comb begin
        rom_ce_o = (state_q != S_IDLE);
        addr_o   = fetch_pc_q;
        if (byp_s) begin
            if_valid_o = 1'b1;
            if_pc_o    = fetch_pc_q;
            if_inst_o  = inst_i;
        end else if (q_valid_s && !branch_flag_i) begin
            if_valid_o = 1'b1;
            if_pc_o    = pc_mem_q[head_q];
            if_inst_o  = inst_mem_q[head_q];
        end else begin
            if_valid_o = 1'b0;
            if_pc_o    = 32'h00000000;
            if_inst_o  = `NopInst;
        end
        stall_req_o = rst && !if_valid_o;
    end

    // Next-state for the FSM, fetch address, pointers and queue storage.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_FETCH;
            S_FLUSH: state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        if (branch_flag_i) begin
            state_d    = S_FLUSH;
            fetch_pc_d = {branch_target_i[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (wr_en_s) begin
                pc_mem_d[tail_q]   = fetch_pc_q;
                inst_mem_d[tail_q] = inst_i;
                tail_d             = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (push_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            if (wr_en_s && !pop_s) begin
                count_d = count_q + CW'(1);
            end else if (!wr_en_s && pop_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers; reset clears the queue without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                pc_mem_q[i]   <= 32'h00000000;
                inst_mem_q[i] <= 32'h00000000;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: QDEPTH, 4, prefetch queue depth in entries; legal values 2, 4 or 8.
REQ-002 Parameter: RESET_PC, 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 = in reset.
REQ-005 stall_i  input  1  from ctrl.v; 1 = if_id does not accept the head entry this cycle.
REQ-006 branch_flag_i  input  1  redirect request from the execute stage.
REQ-007 branch_target_i  input  32  redirect address; bits [1:0] are ignored and treated as 00.
REQ-008 rom_ce_o  output  1  chip enable to rom_ram.v.
REQ-009 addr_o  output  32  instruction address to rom_ram.v; always equals fetch_pc.
REQ-010 rom_stall_i  input  1  stall_req from rom_ram.v; 1 = inst_i is not valid this cycle.
REQ-011 inst_i  input  32  instruction word from rom_ram.v for addr_o.
REQ-012 if_pc_o  output  32  PC of the head entry, to if_id.v.
REQ-013 if_inst_o  output  32  instruction of the head entry, to if_id.v.
REQ-014 if_valid_o  output  1  1 = if_pc_o and if_inst_o are meaningful.
REQ-015 stall_req_o  output  1  to ctrl.v; 1 when if_valid_o=0 and rst=1.

Function
REQ-016 FSM states SHALL be S_IDLE, S_FETCH and S_FLUSH.
REQ-017 In S_IDLE, rom_ce_o=0; the next edge moves to S_FETCH.
REQ-018 In S_FETCH, rom_ce_o=1.
REQ-019 Push condition: state=S_FETCH, rom_stall_i=0, branch_flag_i=0, and (count<QDEPTH or pop).
REQ-020 On a push edge, the entry {addr_o, inst_i} is written at the tail and fetch_pc increments by 4, with 32-bit wrap-around (32'hFFFFFFFC -> 0).
REQ-021 Pop condition: if_valid_o=1, stall_i=0 and branch_flag_i=0; the head advances on that edge.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged, including when count=QDEPTH.
REQ-023 When the queue is full and there is no pop, addr_o holds and no push occurs; the rom read is simply reissued.
REQ-024 When rom_stall_i=1, there is no push and fetch_pc holds; pops continue normally.
REQ-025 On a branch_flag_i=1 edge in any state, the queue is emptied (count=0) and fetch_pc becomes {branch_target_i[31:2],2'b00}.
REQ-026 The same edge moves the FSM to S_FLUSH, and the branch overrides any simultaneous push or pop.
REQ-027 While branch_flag_i=1, if_valid_o SHALL be forced to 0 combinationally.
REQ-028 In S_FLUSH, rom_ce_o=1 with the new address, no push occurs, and the next edge moves to S_FETCH.
REQ-029 A further branch during S_FLUSH restarts S_FLUSH with the newer target.
REQ-030 Head outputs: if_valid_o=(count!=0); with count=0, if_pc_o=0 and if_inst_o=`NopInst.
REQ-031 Latency: an address issued in cycle N with a push appears at the head no earlier than cycle N+1.
REQ-032 Queue pointers are log2(QDEPTH) bits wide and wrap modulo QDEPTH; count is log2(QDEPTH)+1 bits wide.

Reset
REQ-033 While rst=0: state=S_IDLE, fetch_pc=RESET_PC, count=0 and both pointers=0.
REQ-034 While rst=0: rom_ce_o=0, addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=`NopInst and stall_req_o=0.
REQ-035 Reset asserted mid-operation discards all queue entries immediately, without waiting for a clock edge.
REQ-036 After reset release, the first rising edge enters S_FETCH, and the first push can occur on the second edge.

Configuration
REQ-037 Macro FETCH_BYPASS_EN: when defined, a push condition with count=0 presents {addr_o, inst_i} on the head outputs combinationally in the same cycle with if_valid_o=1.
REQ-038 Under FETCH_BYPASS_EN, if stall_i=0 in that same cycle, the entry is consumed and not written into the queue.
REQ-039 When FETCH_BYPASS_EN is undefined, there is no bypass and the minimum latency is one cycle (REQ-031).

Verification
REQ-040 Reset release, rom returns 32'h00000013 every cycle, stall_i=0 -> addr_o advances 0,4,8,... and if_pc_o follows one cycle behind with if_valid_o=1 continuously from the third edge.
REQ-041 stall_i=1 held for 6 cycles with QDEPTH=4 -> count saturates at 4 and addr_o holds at 16; on release, PCs 0,4,8,12,16 emerge in order with no gap.
REQ-042 rom_stall_i=1 for 3 cycles at addr 8 -> no push during those cycles and addr_o stays 8; the queue drains and stall_req_o=1 once count reaches 0.
REQ-043 branch_flag_i=1 with target 32'h00000103 while count=3 -> count=0, addr_o=32'h00000100, if_valid_o=0 for the branch cycle and the next cycle, and the first valid if_pc_o=32'h00000100.
REQ-044 RESET_PC=32'hFFFFFFF8, free-running -> fetched PCs are FFFFFFF8, FFFFFFFC, 00000000.
REQ-045 With FETCH_BYPASS_EN defined, the empty queue receives a push with stall_i=0 -> if_valid_o=1 in the same cycle with if_pc_o=addr_o, and count stays 0.
